// File: rtl/ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_sequencer
// Brief    : Buffers a frame of 24-bit pixels and streams it bit-by-bit to a
//            ws2812_driver, then holds the latch gap. WS2812_BRIGHTNESS_EN
//            adds a global brightness scale applied at pixel load.
// Revision : 1.0
// ============================================================================
module ws2812_frame_sequencer #(
    parameter int NUM_LEDS     = 8,
    parameter int ADDR_W       = 3,
    parameter int LATCH_CYCLES = 1400
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              send_data,
    input  logic              ready
`ifdef WS2812_BRIGHTNESS_EN
    ,
    input  logic [7:0]        brightness
`endif
);

    localparam int                IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [4:0]        LAST_BIT   = 5'd23;
    localparam logic [15:0]       LAST_LATCH = 16'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_ACK   = 3'd4,
        S_DONE  = 3'd5,
        S_LATCH = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       latch_cnt_q, latch_cnt_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;

    logic [23:0]       mem [0:NUM_LEDS-1];
    logic [23:0]       rd_data_q;
    logic [23:0]       load_pix;
    logic              wr_ok;

    assign wr_ok = wr_en && (int'(wr_addr) < NUM_LEDS);

    // Buffer is deliberately not reset; a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        if (state_q == S_FETCH) begin
            rd_data_q <= mem[pix_idx_q[IDX_W-1:0]];
        end
    end

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] lvl);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, lvl} + 16'd1);
        return prod[15:8];
    endfunction

    always_comb begin
        load_pix = {scale(rd_data_q[23:16], brightness),
                    scale(rd_data_q[15:8],  brightness),
                    scale(rd_data_q[7:0],   brightness)};
    end
`else
    always_comb begin
        load_pix = rd_data_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        pix_idx_d   = pix_idx_q;
        bit_cnt_d   = bit_cnt_q;
        latch_cnt_d = latch_cnt_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        send_data   = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    pix_idx_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                {r_d, g_d, b_d} = load_pix;
                bit_cnt_d       = '0;
                state_d         = S_ISSUE;
            end
            S_ISSUE: begin
                if (ready) begin
                    send_data = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (!ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = S_ISSUE;
                    end else if (pix_idx_q != LAST_PIX) begin
                        pix_idx_d = pix_idx_q + ADDR_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        latch_cnt_d = '0;
                        state_d     = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                latch_cnt_d = latch_cnt_q + 16'd1;
                if (latch_cnt_q == LAST_LATCH) begin
                    frame_done  = 1'b1;
                    latch_cnt_d = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            pix_idx_q   <= '0;
            bit_cnt_q   <= '0;
            latch_cnt_q <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            pix_idx_q   <= pix_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign r    = r_q;
    assign g    = g_q;
    assign b    = b_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_frame_sequencer
// Brief    : Self-checking bench: handshake-level reference model, driver
//            model with configurable ready gap, directed and random frames.
// Revision : 1.0
// ============================================================================
module tb_ws2812_frame_sequencer;

    localparam int NUM_LEDS     = 2;
    localparam int ADDR_W       = 2;
    localparam int LATCH_CYCLES = 16;
    localparam int BITS         = 24 * NUM_LEDS;

    logic              clk = 1'b0;
    logic              n_reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [23:0]       wr_data = '0;
    logic              frame_start = 1'b0;
    logic              drv_ready = 1'b1;
    logic              hold_low = 1'b0;
    logic              ready;
    logic              busy, frame_done, send_data;
    logic [7:0]        r, g, b;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]        brightness = 8'd255;
`endif

    assign ready = drv_ready && !hold_low;

    ws2812_frame_sequencer #(
        .NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W), .LATCH_CYCLES(LATCH_CYCLES)
    ) dut (
        .clk(clk), .n_reset(n_reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .r(r), .g(g), .b(b),
        .send_data(send_data), .ready(ready)
`ifdef WS2812_BRIGHTNESS_EN
        , .brightness(brightness)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver model: ready drops the cycle after a request, returns drv_delay cycles later.
    int drv_delay = 30;
    initial begin
        forever begin
            @(negedge clk);
            if (send_data) begin
                @(posedge clk);
                #1 drv_ready = 1'b0;
                repeat (drv_delay) @(posedge clk);
                #1 drv_ready = 1'b1;
            end
        end
    end

    // Reference model state
    logic [23:0] shadow [NUM_LEDS];
    logic [23:0] rgb_at [BITS];
    logic [23:0] m_snap = '0;
    int  m_phase = 0;      // 0 idle, 1 awaiting request, 2 awaiting ready low, 3 awaiting ready high, 4 latch
    bit  m_busy = 1'b0;
    int  m_pulses = 0;
    int  m_earliest = 0;
    int  m_done_at = -1;
    int  frame_pulses = 0;
    int  first_sd_cyc = -1;
    int  n_done = 0;
    int  done_cyc = -1;
    int  last_rise_cyc = -1;
    bit  exp_sd, exp_done, was_idle;

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] sc(input logic [7:0] x);
        int v;
        v = (int'(x) * (int'(brightness) + 1)) / 256;
        return v[7:0];
    endfunction
`endif

    function automatic logic [23:0] exp_pix(input int p);
        logic [23:0] c;
        c = shadow[p];
`ifdef WS2812_BRIGHTNESS_EN
        return {sc(c[23:16]), sc(c[15:8]), sc(c[7:0])};
`else
        return c;
`endif
    endfunction

    always @(negedge clk) begin
        if (!n_reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_send", send_data, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_rgb", {r, g, b}, 0);
            m_phase = 0;
            m_busy  = 1'b0;
            m_pulses = 0;
        end else begin
            was_idle = (m_phase == 0);
            exp_sd   = (m_phase == 1) && (cyc >= m_earliest) && ready;
            exp_done = (m_phase == 4) && (cyc == m_done_at);
            chk("busy", busy, m_busy);
            chk("send_data", send_data, exp_sd);
            chk("frame_done", frame_done, exp_done);
            if (send_data) begin
                frame_pulses++;
                if (first_sd_cyc < 0) first_sd_cyc = cyc;
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (exp_sd && (m_pulses % 24 == 0)) m_snap = exp_pix(m_pulses / 24);
            if (m_busy && (exp_sd || (m_pulses % 24 != 0))) chk("rgb", {r, g, b}, m_snap);
            if (exp_sd) rgb_at[m_pulses] = {r, g, b};
            case (m_phase)
                1: if (exp_sd) begin
                    m_pulses++;
                    m_phase = 2;
                end
                2: if (!ready) m_phase = 3;
                3: if (ready) begin
                    if (m_pulses == BITS) begin
                        m_phase       = 4;
                        m_done_at     = cyc + LATCH_CYCLES;
                        last_rise_cyc = cyc;
                    end else begin
                        m_phase    = 1;
                        m_earliest = (m_pulses % 24 == 0) ? cyc + 3 : cyc + 1;
                    end
                end
                4: if (exp_done) begin
                    m_phase = 0;
                    m_busy  = 1'b0;
                end
                default: ;
            endcase
            if (was_idle && frame_start) begin
                m_phase      = 1;
                m_busy       = 1'b1;
                m_pulses     = 0;
                m_earliest   = cyc + 3;
                frame_pulses = 0;
                first_sd_cyc = -1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int addr, input logic [23:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        if (addr < NUM_LEDS) shadow[addr] = data;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(1); k++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!frame_done && k < budget) begin tick(1); k++; end
        chk("done_timeout", frame_done, 1);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (m_pulses < n && k < budget) begin tick(1); k++; end
        chk("pulse_timeout", (m_pulses >= n) ? 1 : 0, 1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stim
        int t0, d0, rel;
        #1 n_reset = 1'b0;
        tick(3);
        chk("reset_busy", busy, 0);
        chk("reset_rgb", {r, g, b}, 0);
        n_reset = 1'b1;
        tick(2);

        // Two-pixel frame with an ignored restart request mid-frame
        write_px(0, 24'hFF0000);
        write_px(1, 24'h00A55A);
        d0 = n_done;
        t0 = cyc;
        start_frame();
        wait_pulses(30, 3000);
        start_frame();
        wait_done(4000);
        tick(1);
        chk("f1_pulses", frame_pulses, 48);
        chk("f1_first_sd", first_sd_cyc, t0 + 3);
        chk("f1_px0_first", rgb_at[0], 24'hFF0000);
        chk("f1_px0_last", rgb_at[23], 24'hFF0000);
        chk("f1_px1_first", rgb_at[24], 24'h00A55A);
        chk("f1_px1_last", rgb_at[47], 24'h00A55A);
        chk("f1_latch_gap", done_cyc - last_rise_cyc, 16);

        // Restart in the cycle after frame_done; rewrite pixel 1 mid-frame
        start_frame();
        chk("restart_busy", busy, 1);
        wait_pulses(5, 3000);
        write_px(1, 24'h123456);
        wait_idle(4000);
        chk("f2_pulses", frame_pulses, 48);
        chk("f2_px0", rgb_at[0], 24'hFF0000);
        chk("f2_px1", rgb_at[24], 24'h123456);
        chk("done_count", n_done - d0, 2);

        // Asynchronous reset during the 10th bit
        start_frame();
        wait_pulses(10, 3000);
        tick(4);
        #2 n_reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_send", send_data, 0);
        chk("arst_rgb", {r, g, b}, 0);
        tick(3);
        n_reset = 1'b1;
        tick(2);
        start_frame();
        wait_idle(4000);
        chk("post_rst_pulses", frame_pulses, 48);

        // ready held low for 100 cycles at frame start
        hold_low = 1'b1;
        start_frame();
        tick(100);
        chk("hold_no_sd", frame_pulses, 0);
        rel = cyc;
        hold_low = 1'b0;
        wait_idle(4000);
        chk("hold_first_sd", first_sd_cyc, rel);

`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'd127;
        write_px(0, 24'hFF8001);
        start_frame();
        wait_idle(4000);
        chk("bright_px0", rgb_at[0], 24'h7F4000);
        brightness = 8'd255;
`endif

        // Random frames: random pixels, driver gap, mid-frame writes and ignored starts
        for (int f = 0; f < 5; f++) begin
            int k;
            drv_delay = $urandom_range(1, 40);
`ifdef WS2812_BRIGHTNESS_EN
            brightness = 8'($urandom_range(0, 255));
`endif
            write_px(0, 24'($urandom));
            write_px(1, 24'($urandom));
            start_frame();
            k = 0;
            while (busy && k < 6000) begin
                if (m_pulses < 46 && ($urandom % 8) == 0) begin
                    start_frame();
                end else if ((m_pulses % 24) >= 3 && (m_pulses % 24) <= 20 && ($urandom % 16) == 0) begin
                    write_px(int'($urandom_range(0, 3)), 24'($urandom));
                end else begin
                    tick(1);
                end
                k++;
            end
            chk("rand_idle", busy, 0);
            chk("rand_pulses", frame_pulses, 48);
        end
        drv_delay = 30;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_frame_sequencer.md
# ws2812_frame_sequencer

- Upstream feeder for `ws2812_driver`.
- Holds a frame of NUM_LEDS 24-bit pixels in an internal buffer and, on request, streams them pixel by pixel onto the driver's `r`/`g`/`b` inputs.
- Issues 24 `send_data`/`ready` bit handshakes per pixel, holding colour stable throughout.
- After the last pixel, holds the line idle for the WS2812 latch period and then signals frame completion to the host logic.

## Interface
Parameters:
- NUM_LEDS, 8, pixels per frame (1..1024)
- ADDR_W, 3, buffer address width; must satisfy 2**ADDR_W >= NUM_LEDS
- LATCH_CYCLES, 1400, idle cycles after the last bit (56 us at 25 MHz); minimum 1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- wr_en  in  1  pixel buffer write strobe
- wr_addr  in  ADDR_W  pixel index to write; writes with wr_addr >= NUM_LEDS are ignored
- wr_data  in  24  pixel value {r[7:0], g[7:0], b[7:0]}
- frame_start  in  1  single-cycle request to transmit the frame
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  one-cycle pulse at end of the latch period
- r, g, b  out  8 each  colour to driver, registered
- send_data  out  1  one-cycle bit request to driver
- ready  in  1  driver idle/accept indication
- brightness  in  8  global scale; present only with WS2812_BRIGHTNESS_EN

## Operation
- Buffer: NUM_LEDS x 24 synchronous-read RAM.
  - Write port is independent of the FSM; writes are allowed at any time, including mid-frame.
  - On a same-cycle read and write to the same address, the read returns the old data.
- Counters:
  - pix_idx (ADDR_W bits) counts 0..NUM_LEDS-1.
  - bit_cnt (5 bits) counts 0..23.
  - latch_cnt (16 bits) counts 0..LATCH_CYCLES-1.
- FSM states and transitions:
  - IDLE: `busy`=0. On `frame_start`=1: clear pix_idx → FETCH.
  - FETCH: present pix_idx to the RAM read port → LOAD.
  - LOAD: register RAM output onto r/g/b; clear bit_cnt → ISSUE.
  - ISSUE: if `ready`=1, assert `send_data` for this cycle → ACK; otherwise stay.
  - ACK: wait for `ready`=0 → DONE.
  - DONE: wait for `ready`=1. Then:
    - If bit_cnt≠23: increment bit_cnt → ISSUE.
    - Else if pix_idx≠NUM_LEDS-1: increment pix_idx → FETCH.
    - Else: clear latch_cnt → LATCH.
  - LATCH: increment latch_cnt. At LATCH_CYCLES-1: pulse `frame_done` → IDLE.
- r/g/b change only in LOAD; they are stable for all 24 handshakes of a pixel.
- `frame_start` outside IDLE is ignored; it is not queued.
- Reset, at any point including mid-frame: state=IDLE; r=g=b=0; `send_data`=0; `busy`=0; `frame_done`=0; all counters 0. Buffer contents are undefined after power-up and are not cleared by reset.

## Timing
- `frame_start` sampled high in cycle T:
  - `busy`=1 from T+1.
  - RAM address presented in T+1.
  - r/g/b valid at T+3.
  - Earliest `send_data` at T+3.
- `send_data` is never high in two consecutive cycles.
- `send_data` is asserted only in a cycle where `ready`=1.
- Per-bit overhead beyond driver time: 2 cycles (ACK→DONE detect, DONE→ISSUE).
- Per-pixel overhead: 2 additional cycles (FETCH, LOAD).
- `frame_done` is high exactly one cycle, coincident with the last LATCH cycle.
- `busy` falls in the cycle after `frame_done`.
- A `frame_start` in the cycle after `frame_done` is accepted.
- NUM_LEDS=1: after bit 23, go directly to LATCH with no pix_idx increment.
- If `ready` is held low indefinitely, the FSM waits in ISSUE or DONE with no timeout.

## Configuration
- WS2812_BRIGHTNESS_EN defined:
  - The `brightness` port exists.
  - In LOAD, each channel is loaded as (c × (brightness+1)) >> 8, using a 16-bit product truncated to 8 bits.
  - brightness=255 passes values unchanged; brightness=0 gives c>>8 = 0.
  - `brightness` is sampled only in LOAD.
- WS2812_BRIGHTNESS_EN undefined:
  - The `brightness` port is absent.
  - Channels are loaded unmodified.
  - Timing is identical in both cases.

## Test plan
Benches use NUM_LEDS=2 and LATCH_CYCLES=16; the driver is modelled with `ready` dropping 1 cycle after `send_data` and returning 30 cycles later.
- Write 0xFF0000 @0 and 0x00A55A @1; pulse `frame_start` → exactly 48 `send_data` pulses. r/g/b = FF/00/00 for pulses 1–24 and 00/A5/5A for pulses 25–48. `frame_done` is a single pulse exactly 16 cycles after the 48th `ready` rise.
- `frame_start` pulsed again while `busy` → ignored; total pulse count remains 48; no second `frame_done`.
- Write 0x123456 @1 while pixel 0 is transmitting → pixel 1 is sent as 12/34/56.
- Assert `n_reset`=0 during the 10th bit → `busy`, `send_data` and r/g/b go to 0 asynchronously. After release, a new `frame_start` yields a full 48-pulse frame.
- Hold `ready`=0 for 100 cycles while in ISSUE → no `send_data` pulse; the first pulse occurs in the first cycle `ready`=1.
- With WS2812_BRIGHTNESS_EN, brightness=127 and pixel 0xFF8001 → r=0x7F, g=0x40, b=0x00.
